pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-address sequencer for an in-order pipeline front end.
//               Advances the fetch PC sequentially, honours downstream stall,
//               redirects on taken branches with a programmable run of bubble
//               cycles, and parks in a halt state that only reset can leave.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               stall, halt         - downstream back-pressure / stop request
//               brValid, brTaken,
//               brTarget[31:0]      - resolved control instruction from execute
//               fetchPc[31:0]       - registered fetch address
//               fetchValid          - fetchPc is a live request
//               flush               - kill younger instructions (combinational)
//               halted              - sequencer is parked
//               misalign            - sticky: misaligned taken target seen
//               redirectCount[15:0] - saturating count of taken redirects
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter logic [31:0] PC_INC      = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic        brValid,
  input  logic        brTaken,
  input  logic [31:0] brTarget,
  output logic [31:0] fetchPc,
  output logic        fetchValid,
  output logic        flush,
  output logic        halted,
  output logic        misalign,
  output logic [15:0] redirectCount
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [2:0] c_depth = 3'(FLUSH_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic        w_redirect;

  // A parked sequencer ignores the execute stage entirely.
  assign w_redirect = brValid && brTaken && (state_q != ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
      mis_q   <= 1'b0;
      rcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    rcnt_d  = rcnt_q;
    if (w_redirect) begin
      // Redirect outranks stall and halt; newest redirect restarts the bubble run.
      pc_d    = {brTarget[31:2], 2'b00};
      cnt_d   = c_depth;
      state_d = (c_depth != 3'd0) ? ST_FLUSH : ST_RUN;
      if (brTarget[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
      if (rcnt_q != 16'hFFFF) begin
        rcnt_d = rcnt_q + 16'd1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt) begin
            state_d = ST_HALT;
          end else if (!stall) begin
            pc_d = pc_q + PC_INC;
          end
        end
        ST_FLUSH: begin
          // Bubbles drain independently of stall; halt is not honoured here.
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign fetchPc       = pc_q;
  assign fetchValid    = (state_q == ST_RUN) && !rst;
  assign flush         = w_redirect && !rst;
  assign halted        = (state_q == ST_HALT);
  assign misalign      = mis_q;
  assign redirectCount = rcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Three instances with
//               different parameter sets share one stimulus stream; each is
//               compared every cycle with an abstract reference model, and
//               directed scenarios add fixed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        brValid = 1'b0;
  logic        brTaken = 1'b0;
  logic [31:0] brTarget = 32'h0;

  logic [31:0] o_pc    [3];
  logic        o_valid [3];
  logic        o_flush [3];
  logic        o_halt  [3];
  logic        o_mis   [3];
  logic [15:0] o_cnt   [3];

  always #5 clk = ~clk;

  pc_sequencer u0 (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .brValid(brValid), .brTaken(brTaken), .brTarget(brTarget),
    .fetchPc(o_pc[0]), .fetchValid(o_valid[0]), .flush(o_flush[0]),
    .halted(o_halt[0]), .misalign(o_mis[0]), .redirectCount(o_cnt[0])
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .FLUSH_DEPTH(7), .PC_INC(32'd4)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .brValid(brValid), .brTaken(brTaken), .brTarget(brTarget),
    .fetchPc(o_pc[1]), .fetchValid(o_valid[1]), .flush(o_flush[1]),
    .halted(o_halt[1]), .misalign(o_mis[1]), .redirectCount(o_cnt[1])
  );

  pc_sequencer #(.RESET_PC(32'h0000_1000), .FLUSH_DEPTH(0), .PC_INC(32'd8)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .brValid(brValid), .brTaken(brTaken), .brTarget(brTarget),
    .fetchPc(o_pc[2]), .fetchValid(o_valid[2]), .flush(o_flush[2]),
    .halted(o_halt[2]), .misalign(o_mis[2]), .redirectCount(o_cnt[2])
  );

  // Reference model: parameters and abstract state per instance.
  logic [31:0] P_RST [3];
  int          P_DEP [3];
  logic [31:0] P_INC [3];
  logic [31:0] m_pc   [3];
  int          m_bub  [3];   // bubble cycles still owed
  bit          m_halt [3];
  bit          m_mis  [3];
  int          m_cnt  [3];
  bit          model_ok = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_pc[i] = P_RST[i]; m_bub[i] = 0; m_halt[i] = 1'b0; m_mis[i] = 1'b0; m_cnt[i] = 0;
      end else if (m_halt[i]) begin
        m_pc[i] = m_pc[i];
      end else if (brValid && brTaken) begin
        m_pc[i]  = brTarget & 32'hFFFF_FFFC;
        m_bub[i] = P_DEP[i];
        m_cnt[i] = (m_cnt[i] >= 65535) ? 65535 : m_cnt[i] + 1;
        if (brTarget % 4 != 0) m_mis[i] = 1'b1;
      end else if (m_bub[i] > 0) begin
        m_bub[i] = m_bub[i] - 1;
      end else if (halt) begin
        m_halt[i] = 1'b1;
      end else if (!stall) begin
        m_pc[i] = m_pc[i] + P_INC[i];
      end
    end
    if (rst) model_ok = 1'b1;
  endtask

  task automatic compare_model();
    bit live;
    for (int i = 0; i < 3; i++) begin
      live = !rst && !m_halt[i];
      chk($sformatf("u%0d.fetchPc", i),       o_pc[i],    m_pc[i]);
      chk($sformatf("u%0d.fetchValid", i),    32'(o_valid[i]), 32'(live && (m_bub[i] == 0)));
      chk($sformatf("u%0d.flush", i),         32'(o_flush[i]), 32'(live && brValid && brTaken));
      chk($sformatf("u%0d.halted", i),        32'(o_halt[i]),  32'(m_halt[i]));
      chk($sformatf("u%0d.misalign", i),      32'(o_mis[i]),   32'(m_mis[i]));
      chk($sformatf("u%0d.redirectCount", i), 32'(o_cnt[i]),   32'(m_cnt[i]));
    end
  endtask

  // Close the current cycle, drive the next cycle's inputs, sample mid-cycle.
  task automatic step(input bit rs, input bit st, input bit hl, input bit bv,
                      input bit bt, input logic [31:0] tg);
    @(posedge clk);
    model_update();
    #1;
    rst = rs; stall = st; halt = hl; brValid = bv; brTaken = bt; brTarget = tg;
    @(negedge clk);
    if (model_ok) compare_model();
  endtask

  logic [31:0] exp_seq [7];
  bit          stl_seq [7];

  initial begin
    P_RST[0] = 32'h0;         P_DEP[0] = 2; P_INC[0] = 32'd4;
    P_RST[1] = 32'hFFFF_FFF8; P_DEP[1] = 7; P_INC[1] = 32'd4;
    P_RST[2] = 32'h0000_1000; P_DEP[2] = 0; P_INC[2] = 32'd8;
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'h10};
    stl_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset with a same-cycle redirect: outputs must stay quiet.
    step(1, 0, 0, 1, 1, 32'h80);
    chk("rst.flush", 32'(o_flush[0]), 32'h0);
    chk("rst.valid", 32'(o_valid[0]), 32'h0);
    chk("rst.pc", o_pc[0], 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("rst.count", 32'(o_cnt[0]), 32'h0);

    // Sequential fetch with stall; u1 wraps through zero.
    for (int k = 0; k < 7; k++) begin
      step(0, stl_seq[k], 0, 0, 0, 32'h0);
      chk($sformatf("seq.pc[%0d]", k), o_pc[0], exp_seq[k]);
      chk($sformatf("seq.valid[%0d]", k), 32'(o_valid[0]), 32'h1);
    end

    // Taken redirect at pc 8.
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("wrap.pc0", o_pc[1], 32'hFFFF_FFF8);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("wrap.pc1", o_pc[1], 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 1, 32'h100);
    chk("wrap.pc2", o_pc[1], 32'h0);
    chk("br.pc_at", o_pc[0], 32'h8);
    chk("br.flush", 32'(o_flush[0]), 32'h1);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("br.bubble1", 32'(o_valid[0]), 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("br.bubble2", 32'(o_valid[0]), 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("br.valid", 32'(o_valid[0]), 32'h1);
    chk("br.pc_tgt", o_pc[0], 32'h100);
    chk("br.count", 32'(o_cnt[0]), 32'h1);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("br.pc_next", o_pc[0], 32'h104);

    // Redirect during FLUSH with a misaligned target.
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 1, 32'h100);
    step(0, 0, 0, 1, 1, 32'h203);
    chk("re.flush2", 32'(o_flush[0]), 32'h1);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("re.bubble1", 32'(o_valid[0]), 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("re.bubble2", 32'(o_valid[0]), 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("re.pc", o_pc[0], 32'h200);
    chk("re.valid", 32'(o_valid[0]), 32'h1);
    chk("re.misalign", 32'(o_mis[0]), 32'h1);
    chk("re.count", 32'(o_cnt[0]), 32'h2);

    // Not-taken branch, halt vs redirect priority, then halt alone.
    step(0, 0, 0, 1, 0, 32'h300);
    chk("nt.pc", o_pc[0], 32'h204);
    chk("nt.flush", 32'(o_flush[0]), 32'h0);
    step(0, 0, 1, 1, 1, 32'h40);
    chk("nt.seq", o_pc[0], 32'h208);
    chk("hp.flush", 32'(o_flush[0]), 32'h1);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("hp.not_halted", 32'(o_halt[0]), 32'h0);
    chk("hp.pc", o_pc[0], 32'h40);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 32'h0);
    chk("hp.run", 32'(o_valid[0]), 32'h1);
    step(0, 1, 1, 1, 1, 32'h300);
    chk("halt.halted", 32'(o_halt[0]), 32'h1);
    chk("halt.valid", 32'(o_valid[0]), 32'h0);
    chk("halt.flush", 32'(o_flush[0]), 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("halt.pc", o_pc[0], 32'h40);
    chk("halt.persist", 32'(o_halt[0]), 32'h1);

    // Reset during the first FLUSH cycle.
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("rmid.unhalted", 32'(o_halt[0]), 32'h0);
    step(0, 0, 0, 1, 1, 32'h100);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("rmid.valid_rst", 32'(o_valid[0]), 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("rmid.pc", o_pc[0], 32'h0);
    chk("rmid.valid_held", 32'(o_valid[0]), 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("rmid.valid_rel", 32'(o_valid[0]), 32'h1);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("rmid.pc_next", o_pc[0], 32'h4);

    // Randomised traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(99) < 3, $urandom_range(99) < 30, $urandom_range(99) < 3,
           $urandom_range(99) < 25, $urandom_range(99) < 60, $urandom());
    end

    // Saturation of the redirect counter.
    step(1, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 65537; k++) begin
      step(0, 0, 0, 1, 1, $urandom());
    end
    step(0, 0, 0, 0, 0, 32'h0);
    chk("sat.u0", 32'(o_cnt[0]), 32'hFFFF);
    chk("sat.u1", 32'(o_cnt[1]), 32'hFFFF);
    chk("sat.u2", 32'(o_cnt[2]), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
